// File: rtl/filtered_bus_synchronizer.sv
// WIDTH independent level synchronizers, each followed by a stability filter and rise/fall pulse generation.
// Define SYNC_STICKY_EVENT_EN to build the sticky per-channel event flags (event_o / clear_i).
module filtered_bus_synchronizer #(
    parameter int               WIDTH         = 1,
    parameter int               LENGTH        = 3,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] event_o,
    input  logic [WIDTH-1:0] clear_i
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] stage_r [LENGTH];
    logic [WIDTH-1:0] sync_s;
    logic [CNT_W-1:0] cnt_r     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic [WIDTH-1:0] rise_nxt_s;
    logic [WIDTH-1:0] fall_nxt_s;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;

    // Plain flop chain into the clk_i domain; nothing may sit between stages.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < LENGTH; k++) begin
                stage_r[k] <= RESET_VALUE;
            end
        end else begin
            stage_r[0] <= data_i;
            for (int k = 1; k < LENGTH; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign sync_s = stage_r[LENGTH-1];

    // Per-channel stability filter: a new level must persist STABLE_CYCLES cycles before it is accepted.
    always_comb begin
        data_nxt_s = data_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = {CNT_W{1'b0}};
            if (sync_s[i] == data_r[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                data_nxt_s[i] = sync_s[i];
                cnt_nxt_s[i]  = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    assign rise_nxt_s = data_nxt_s & ~data_r;
    assign fall_nxt_s = ~data_nxt_s & data_r;

    // Filter state, filtered level and edge pulses; pulses coincide with the level change.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            data_r <= RESET_VALUE;
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            data_r <= data_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
        end
    end

    assign data_o = data_r;
    assign rise_o = rise_r;
    assign fall_o = fall_r;

`ifdef SYNC_STICKY_EVENT_EN
    logic [WIDTH-1:0] event_r;

    // Sticky edge flags; a new edge in the same cycle overrides a clear.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            event_r <= {WIDTH{1'b0}};
        end else begin
            event_r <= (event_r & ~clear_i) | rise_nxt_s | fall_nxt_s;
        end
    end

    assign event_o = event_r;
`else
    logic unused_clear_s;

    assign unused_clear_s = ^clear_i;
    assign event_o        = {WIDTH{1'b0}};
`endif

endmodule
